// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction field positions, control-word
// layout and the canonical NOP encoding.
package mips_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

  // 8-bit control word carried into ID/EX: WB[7:6] M[5:4] ALUSrc[3] ALUOp[2:1] RegDst[0]
  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
  } ctrl_word_t;

  localparam int unsigned MEM_READ_BIT = 1;

  function automatic logic [4:0] rs_of(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection: stall when the load in ID/EX writes a register
// read by the instruction in IF/ID.
module hazard_detect_unit (
  input  logic       valid_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       id_ex_memread_i,
  input  logic [4:0] id_ex_rt_i,
  output logic       stall_o
);

  // rt is compared even for I-type consumers where it is a destination: conservative.
  always_comb begin
    stall_o = valid_i & id_ex_memread_i & (id_ex_rt_i != 5'd0) &
              ((id_ex_rt_i == rs_i) | (id_ex_rt_i == rt_i));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch/jump flush and
// saturating stall/flush event counters.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      pc_add4_i,
  input  logic [31:0]      instr_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  output logic [31:0]      pc_add4_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic             pc_write_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic stall;
  logic flush;

  hazard_detect_unit u_hazard (
    .valid_i         (valid_o),
    .rs_i            (rs_of(instr_o)),
    .rt_i            (rt_of(instr_o)),
    .id_ex_memread_i (id_ex_memread_i),
    .id_ex_rt_i      (id_ex_rt_i),
    .stall_o         (stall)
  );

  // Branch/jump inputs are unqualified while stalled, so a stall masks the flush.
  always_comb begin
    flush      = (branch_taken_i | jump_i) & ~stall;
    pc_write_o = ~stall;
    bubble_o   = stall;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_add4_o <= '0;
      instr_o   <= NOP;
      valid_o   <= 1'b0;
    end else if (stall) begin
      pc_add4_o <= pc_add4_o;
      instr_o   <= instr_o;
      valid_o   <= valid_o;
    end else if (flush) begin
      pc_add4_o <= pc_add4_i;
      instr_o   <= NOP;
      valid_o   <= 1'b0;
    end else begin
      pc_add4_o <= pc_add4_i;
      instr_o   <= instr_i;
      valid_o   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares.
module tb_if_id_stage;

  // Narrow counters so saturation is reachable in a short run.
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc_add4_i, instr_i;
  logic          id_ex_memread_i;
  logic [4:0]    id_ex_rt_i;
  logic          branch_taken_i, jump_i;
  logic [31:0]   pc_add4_o, instr_o;
  logic          valid_o, pc_write_o, bubble_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  if_id_stage #(.CNT_W(CW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .pc_add4_i       (pc_add4_i),
    .instr_i         (instr_i),
    .id_ex_memread_i (id_ex_memread_i),
    .id_ex_rt_i      (id_ex_rt_i),
    .branch_taken_i  (branch_taken_i),
    .jump_i          (jump_i),
    .pc_add4_o       (pc_add4_o),
    .instr_o         (instr_o),
    .valid_o         (valid_o),
    .pc_write_o      (pc_write_o),
    .bubble_o        (bubble_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        pcw;
    logic        bub;
    int          sc;
    int          fc;
    string       tag;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural contents of IF/ID plus event totals.
  logic [31:0] m_pc, m_instr;
  logic        m_valid;
  int          m_sc, m_fc;

  task automatic chk(input string name, input string tag, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s [%s]: got %0h, expected %0h at %0t", name, tag, act, req, $time);
    end
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instr_o",     e.tag, longint'(instr_o),     longint'(e.instr));
        chk("pc_add4_o",   e.tag, longint'(pc_add4_o),   longint'(e.pc));
        chk("valid_o",     e.tag, longint'(valid_o),     longint'(e.valid));
        chk("pc_write_o",  e.tag, longint'(pc_write_o),  longint'(e.pcw));
        chk("bubble_o",    e.tag, longint'(bubble_o),    longint'(e.bub));
        chk("stall_cnt_o", e.tag, longint'(stall_cnt_o), longint'(e.sc));
        chk("flush_cnt_o", e.tag, longint'(flush_cnt_o), longint'(e.fc));
      end
    end
  end

  function automatic void push_exp(input logic st, input string tag);
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.valid = m_valid;
    e.pcw = !st; e.bub = st; e.sc = m_sc; e.fc = m_fc; e.tag = tag;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
  endfunction

  // One cycle: entered at posedge+1, drives inputs, records expectation, advances model.
  task automatic cycle(input logic [31:0] pc, input logic [31:0] ins, input logic mr,
                       input logic [4:0] rt, input logic br, input logic jp, input string tag);
    logic [4:0] rs_f, rt_f;
    logic st, fl;
    pc_add4_i = pc; instr_i = ins; id_ex_memread_i = mr; id_ex_rt_i = rt;
    branch_taken_i = br; jump_i = jp;
    rs_f = m_instr[25:21];
    rt_f = m_instr[20:16];
    st = m_valid && mr && (rt != 5'd0) && ((rt == rs_f) || (rt == rt_f));
    fl = (br || jp) && !st;
    push_exp(st, tag);
    @(posedge clk);
    if (st) begin
      m_sc = (m_sc < MAX) ? m_sc + 1 : MAX;
    end else if (fl) begin
      m_pc = pc; m_instr = 32'h0; m_valid = 1'b0;
      m_fc = (m_fc < MAX) ? m_fc + 1 : MAX;
    end else begin
      m_pc = pc; m_instr = ins; m_valid = 1'b1;
    end
    #1;
  endtask

  // Assert reset one unit into the cycle; the check lands before the next rising edge.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    model_reset();
    push_exp(1'b0, tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    op  = 6'($urandom);
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] LW  = 32'h8C22_0004;
  localparam logic [31:0] ADD = 32'h0044_1820;

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    pc_add4_i = '0; instr_i = '0; id_ex_memread_i = 1'b0; id_ex_rt_i = '0;
    branch_taken_i = 1'b0; jump_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_exp(1'b0, "reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    cycle(32'h4, LW, 1'b0, 5'd0, 1'b0, 1'b0, "post_reset");
    cycle(32'h8, ADD, 1'b0, 5'd0, 1'b0, 1'b0, "lw_loaded");
    cycle(32'hC, 32'h1234_5678, 1'b1, 5'd2, 1'b0, 1'b0, "load_use");
    cycle(32'hC, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 1'b0, "after_stall");
    cycle(32'h10, ADD, 1'b0, 5'd0, 1'b0, 1'b0, "reload_add");
    cycle(32'h14, LW, 1'b1, 5'd0, 1'b0, 1'b0, "rt_zero");
    cycle(32'h18, ADD, 1'b0, 5'd0, 1'b1, 1'b0, "branch");
    cycle(32'h40, LW, 1'b0, 5'd0, 1'b0, 1'b0, "flushed");
    cycle(32'h44, ADD, 1'b0, 5'd0, 1'b0, 1'b1, "jump");
    cycle(32'h80, ADD, 1'b0, 5'd0, 1'b0, 1'b0, "jump_flushed");
    cycle(32'h84, LW, 1'b1, 5'd4, 1'b1, 1'b0, "stall_beats_branch");
    cycle(32'h84, LW, 1'b0, 5'd0, 1'b0, 1'b0, "stall_beats_branch_after");
    cycle(32'h88, ADD, 1'b0, 5'd0, 1'b0, 1'b0, "load_add_sat");
    for (int i = 0; i < MAX + 4; i++)
      cycle(32'h8C, LW, 1'b1, 5'd2, 1'b0, 1'b0, "stall_saturate");
    for (int i = 0; i < MAX + 4; i++)
      cycle(32'h90 + 32'(i * 4), LW, 1'b0, 5'd0, 1'b0, 1'b1, "flush_saturate");
    cycle(32'hF0, ADD, 1'b0, 5'd0, 1'b0, 1'b0, "pre_reset");
    cycle(32'hF4, LW, 1'b0, 5'd0, 1'b0, 1'b0, "pre_reset2");
    pc_add4_i = 32'hF8; instr_i = LW; id_ex_memread_i = 1'b1; id_ex_rt_i = 5'd2;
    async_reset("reset_mid_stall");
    cycle(32'hF8, LW, 1'b1, 5'd2, 1'b0, 1'b0, "release_loads");

    for (int i = 0; i < 400; i++) begin
      cycle(32'($urandom) & 32'hFFFF_FFFC, rand_instr(), 1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), "random");
      if (i == 200) async_reset("random_reset");
    end

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection, branch/jump flush and stall/flush event counters. Sits between instruction fetch (PC, instruction memory, PC+4 adder) and the decode stage that feeds the ID/EX register. Registers the fetched instruction and PC+4. Produces the PC write-enable for fetch and the bubble select that zeroes the 8-bit control word entering ID/EX.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- pc_add4_i  input  32  PC+4 from the fetch adder
- instr_i  input  32  instruction word from instruction memory
- id_ex_memread_i  input  1  MemRead bit of the control word currently in ID/EX (M field bit 1)
- id_ex_rt_i  input  5  RT address currently in ID/EX (load destination)
- branch_taken_i  input  1  branch resolved taken in ID this cycle
- jump_i  input  1  jump decoded in ID this cycle
- pc_add4_o  output  32  registered PC+4
- instr_o  output  32  registered instruction
- valid_o  output  1  instr_o is a real instruction (0 = injected NOP)
- pc_write_o  output  1  fetch PC may update this cycle
- bubble_o  output  1  ID/EX must load an all-zero control word this cycle
- stall_cnt_o  output  CNT_W  load-use stall cycles since reset, saturating
- flush_cnt_o  output  CNT_W  flush events since reset, saturating

## Operation
- Decode fields from instr_o: rs = [25:21], rt = [20:16].
- stall (combinational) = valid_o & id_ex_memread_i & (id_ex_rt_i != 0) & ((id_ex_rt_i == rs) | (id_ex_rt_i == rt)). Comparison against both fields is deliberate and conservative.
- flush (combinational) = (branch_taken_i | jump_i) & ~stall.
- pc_write_o = ~stall. bubble_o = stall.
- Register update, in priority order:
  - Stall: hold pc_add4_o, instr_o and valid_o.
  - Flush: instr_o <= 32'h0000_0000 (NOP); valid_o <= 0; pc_add4_o <= pc_add4_i.
  - Otherwise: instr_o <= instr_i; pc_add4_o <= pc_add4_i; valid_o <= 1.
- Stall dominates flush. During a stall, branch_taken_i and jump_i are unqualified because the branch operands are not ready, so they are ignored.
- Counters:
  - stall_cnt_o increments by 1 on every clock edge where stall = 1.
  - flush_cnt_o increments by 1 on every edge where flush = 1.
  - Both saturate at all-ones and never wrap.
- A NOP (valid_o = 0) in IF/ID never raises stall.

## Timing
- Reset (rst_n_i low, asynchronous): pc_add4_o = 0, instr_o = 0, valid_o = 0, stall_cnt_o = 0, flush_cnt_o = 0.
  - Consequence: pc_write_o = 1 and bubble_o = 0 while in reset.
- Reset deassertion mid-stall: state is cleared, so the stall is dropped. The first edge after release loads instr_i.
- Latency: one cycle from instr_i/pc_add4_i to instr_o/pc_add4_o.
- pc_write_o and bubble_o are combinational from the registered state and the ID/EX inputs, valid in the same cycle.
- Load-use: exactly one stall cycle per dependent load.
  - Next cycle ID/EX holds the bubble (MemRead = 0), so stall deasserts.
- Back-to-back loads each with a dependent consumer: one stall per pair. There are never two consecutive stall cycles from the same load.
- Flush removes exactly one instruction, the one fetched in the delay slot.

## Structure
- Shared package (mips_pkg):
  - NOP constant 32'h0000_0000
  - RS/RT/RD field bit ranges
  - control-word field positions: WB[7:6], M[5:4], ALUSrc[3], ALUOp[2:1], RegDst[0]
  - MemRead bit index within M
- Sub-module hazard_detect_unit: pure combinational stall equation; instantiated once.
- Counters and register live in if_id_stage.

## Test plan
- Reset then release; instr_i = 0x8C22_0004 (lw $2,4($1)), pc_add4_i = 0x4 -> after 1 edge instr_o = 0x8C22_0004, valid_o = 1, pc_add4_o = 0x4, counters 0.
- instr_o = add $3,$2,$4 (0x0044_1820), id_ex_memread_i = 1, id_ex_rt_i = 2 -> stall cycle:
  - pc_write_o = 0, bubble_o = 1, instr_o held.
  - stall_cnt_o = 1.
  - Next cycle, with memread dropped: normal advance.
- Same as above but id_ex_rt_i = 0 -> no stall; pc_write_o = 1, stall_cnt_o stays 0.
- branch_taken_i = 1, no hazard -> next instr_o = 0, valid_o = 0, flush_cnt_o = 1; following cycle loads the target instruction with valid_o = 1.
- branch_taken_i = 1 coincident with stall condition -> stall wins: instr_o held, flush_cnt_o unchanged, stall_cnt_o +1.
- Force stall_cnt_o to 0xFFFF (CNT_W = 16) and stall again -> stays 0xFFFF. Assert rst_n_i low mid-cycle -> all outputs clear immediately, without waiting for a clock edge.
